cache_fill_ctrl: RTL and testbench

//  Memory-side miss handler for the 64-entry direct-mapped data cache. Watches CPU read lookups.
//  On a miss it stalls the CPU and fetches the word from main memory over a req/ack handshake.
//  It then writes the word, tag and valid bit into the cache through the cache write port.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_stat_counter.sv | 19 +
 rtl/cache_fill_ctrl.sv | 101 ++++++++++
 tb/tb_cache_fill_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped data cache and its miss handler.
package cache_pkg;

    localparam int TAG_W   = 26;
    localparam int INDEX_W = 6;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } cache_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        ERR  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/cache_stat_counter.sv
// Saturating 32-bit event counter for lookup statistics.
// Only built when CACHE_STATS_EN is defined.
`ifdef CACHE_STATS_EN
module cache_stat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 32'd1;
    end

endmodule
`endif

// File: rtl/cache_fill_ctrl.sv
// Read-miss handler: stalls the CPU, fetches the word over req/ack and writes it into the cache.
// Optional lookup hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              MemHit,
    output logic              stall,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_wren,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              err,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int                CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    fill_state_t       state;
    logic [ADDR_W-1:0] miss_addr;
    logic [DATA_W-1:0] fill_word;
    logic [CNT_W-1:0]  wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            miss_addr <= '0;
            fill_word <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && !MemHit) begin
                        miss_addr <= cpu_addr;
                        wait_cnt  <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fill_word <= mem_rdata;
                        state     <= FILL;
                    end else begin
                        // Counter holds at the limit; ERR is entered on the cycle it gets there.
                        if (wait_cnt != LIMIT)
                            wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == LIMIT - 1'b1)
                            state <= ERR;
                    end
                end
                FILL:    state <= IDLE;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    // A miss stalls combinationally in its own lookup cycle.
    assign stall     = (state != IDLE) || (cpu_req && !MemHit);
    assign mem_rd    = (state == REQ);
    assign mem_addr  = miss_addr;
    assign fill_wren = (state == FILL);
    assign fill_addr = miss_addr;
    assign fill_data = fill_word;
    assign err       = (state == ERR);

`ifdef CACHE_STATS_EN
    logic lookup;
    assign lookup = (state == IDLE) && cpu_req;

    cache_stat_counter u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lookup && MemHit),
        .count (hit_cnt)
    );

    cache_stat_counter u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lookup && !MemHit),
        .count (miss_cnt)
    );
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: hit table, miss fills, reset abort, timeout and counters.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        MemHit;
    logic        stall;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        fill_wren;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        err;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int unsigned vectors = 0;
    int unsigned fails   = 0;
    int unsigned exp_hits   = 0;
    int unsigned exp_misses = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .MemHit    (MemHit),
        .stall     (stall),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .fill_wren (fill_wren),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .err       (err),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        hit;
        logic        exp_stall;
        logic        exp_mem_rd;
        logic        exp_fill;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss at cycle t, ack after lat REQ cycles, fill, then re-lookup hit.
    task automatic do_miss(input logic [31:0] addr, input int unsigned lat, input logic [31:0] data);
        int unsigned rd_cycles = 0;
        cpu_req = 1'b1; cpu_addr = addr; MemHit = 1'b0; mem_ack = 1'b0;
        #1;
        chk("miss_stall", 32'(stall), 32'd1);
        chk("miss_mem_rd_t", 32'(mem_rd), 32'd0);
        exp_misses++;
        tick();
        for (int unsigned k = 0; k <= lat; k++) begin
            cpu_req   = 1'b0;
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? data : 32'h5555_AAAA;
            #1;
            if (mem_rd) rd_cycles++;
            chk("req_mem_addr", mem_addr, addr);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_fill", 32'(fill_wren), 32'd0);
            tick();
        end
        chk("mem_rd_cycles", rd_cycles, lat + 1);
        mem_ack = 1'b0; cpu_req = 1'b1; MemHit = 1'b0;
        #1;
        chk("fill_wren", 32'(fill_wren), 32'd1);
        chk("fill_addr", fill_addr, addr);
        chk("fill_data", fill_data, data);
        chk("fill_mem_rd", 32'(mem_rd), 32'd0);
        chk("fill_stall", 32'(stall), 32'd1);
        tick();
        MemHit = 1'b1;
        #1;
        chk("relookup_stall", 32'(stall), 32'd0);
        chk("relookup_fill", 32'(fill_wren), 32'd0);
        exp_hits++;
        tick();
        cpu_req = 1'b0; MemHit = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0048, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; MemHit = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_fill", 32'(fill_wren), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_fill_addr", fill_addr, 32'd0);
        chk("rst_fill_data", fill_data, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        reset = 1'b0;

        // Hit / idle table: nothing may leave IDLE.
        for (int i = 0; i < 5; i++) begin
            cpu_req = vecs[i].req; cpu_addr = vecs[i].addr; MemHit = vecs[i].hit;
            #1;
            chk("tbl_stall", 32'(stall), 32'(vecs[i].exp_stall));
            chk("tbl_mem_rd", 32'(mem_rd), 32'(vecs[i].exp_mem_rd));
            chk("tbl_fill", 32'(fill_wren), 32'(vecs[i].exp_fill));
            if (vecs[i].req && vecs[i].hit) exp_hits++;
            tick();
        end
        cpu_req = 1'b0;

        do_miss(32'h0000_0104, 3, 32'hDEAD_BEEF);
        do_miss(32'h0000_0208, 0, 32'h1234_5678);

`ifdef CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_misses);
        chk("hit_cnt_const", hit_cnt, 32'd5);
        chk("miss_cnt_const", miss_cnt, 32'd2);
`else
        chk("hit_cnt_off", hit_cnt, 32'd0);
        chk("miss_cnt_off", miss_cnt, 32'd0);
`endif

        // Reset while waiting in REQ, then a late ack must not fill.
        cpu_req = 1'b1; cpu_addr = 32'h0000_0300; MemHit = 1'b0;
        tick();
        cpu_req = 1'b0;
        #1;
        chk("abort_mem_rd_before", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        #1;
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_fill", 32'(fill_wren), 32'd0);
        tick();
        chk("abort_fill_late", 32'(fill_wren), 32'd0);
        chk("abort_fill_data", fill_data, 32'd0);
        mem_ack = 1'b0;

        // No ack: ERR after exactly 8 REQ cycles.
        cpu_req = 1'b1; cpu_addr = 32'h0000_0400; MemHit = 1'b0;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("to_mem_rd", 32'(mem_rd), 32'd1);
            chk("to_err_early", 32'(err), 32'd0);
            tick();
        end
        chk("to_err", 32'(err), 32'd1);
        chk("to_mem_rd_off", 32'(mem_rd), 32'd0);
        chk("to_stall", 32'(stall), 32'd1);
        mem_ack = 1'b1;
        tick();
        tick();
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_no_fill", 32'(fill_wren), 32'd0);
        mem_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("to_err_cleared", 32'(err), 32'd0);
        chk("to_stall_cleared", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
